iommu_ioatc_assoc: RTL

Parametrised, set-associative IO address translation cache for the IOMMU datapath. It sits between the device-side translation request path and the page-table walker. It returns cached IOVA→PA page translations, accepts fills from the walker, and supports single-page and full invalidation. It is the successor to the 128-entry direct-mapped ATC and adds:

- configurable sets and ways
- round-robin replacement
- in-place refresh of an already-cached IOVA
- per-IOVA invalidation
- synchronous reset of all valid state

---
 rtl/iommu_pkg.sv | 28 ++
 rtl/iommu_ioatc_way_sel.sv | 36 +++
 rtl/iommu_ioatc_assoc.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/iommu_pkg.sv
// Shared types and default geometry for the IOMMU address translation cache.
package iommu_pkg;

  localparam int unsigned IOMMU_IOVA_W     = 39;
  localparam int unsigned IOMMU_PA_W       = 56;
  localparam int unsigned IOMMU_PAGE_SHIFT = 12;
  localparam int unsigned IOMMU_SETS       = 64;
  localparam int unsigned IOMMU_IDX_W      = $clog2(IOMMU_SETS);
  localparam int unsigned IOMMU_TAG_W      = IOMMU_IOVA_W - IOMMU_PAGE_SHIFT - IOMMU_IDX_W;
  localparam int unsigned IOMMU_PPN_W      = IOMMU_PA_W - IOMMU_PAGE_SHIFT;

  // Controller states: one request is in flight at a time.
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    UPDATE,
    INV_ONE,
    INV_ALL
  } ioatc_state_e;

  // One cache entry at the default geometry.
  typedef struct packed {
    logic                   valid;
    logic [IOMMU_TAG_W-1:0] tag;
    logic [IOMMU_PPN_W-1:0] ppn;
  } ioatc_entry_t;

endpackage

// File: rtl/iommu_ioatc_way_sel.sv
// Tag compare and way selection for one set of the translation cache.
module iommu_ioatc_way_sel #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned TAG_W = 21,
  parameter int unsigned WAY_W = 1
) (
  input  logic [WAYS-1:0]            i_valid,
  input  logic [WAYS-1:0][TAG_W-1:0] i_tags,
  input  logic [TAG_W-1:0]           i_tag,
  input  logic [WAY_W-1:0]           i_vptr,
  output logic [WAYS-1:0]            o_hit_vec,
  output logic                       o_hit,
  output logic [WAY_W-1:0]           o_hit_way,
  output logic                       o_has_inv,
  output logic [WAY_W-1:0]           o_inv_way,
  output logic [WAY_W-1:0]           o_fill_way
);

  // Descending scan so the lowest matching / invalid way wins.
  always_comb begin
    o_hit_vec = '0;
    o_hit_way = '0;
    o_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      o_hit_vec[w] = i_valid[w] && (i_tags[w] == i_tag);
      if (o_hit_vec[w]) o_hit_way = WAY_W'(w);
      if (!i_valid[w])  o_inv_way = WAY_W'(w);
    end
    o_hit      = |o_hit_vec;
    o_has_inv  = ~&i_valid;
    if (o_hit)          o_fill_way = o_hit_way;
    else if (o_has_inv) o_fill_way = o_inv_way;
    else                o_fill_way = i_vptr;
  end

endmodule

// File: rtl/iommu_ioatc_assoc.sv
// Set-associative IOVA->PA translation cache with round-robin replacement.
module iommu_ioatc_assoc
  import iommu_pkg::*;
#(
  parameter int unsigned IOVA_W     = IOMMU_IOVA_W,
  parameter int unsigned PA_W       = IOMMU_PA_W,
  parameter int unsigned PAGE_SHIFT = IOMMU_PAGE_SHIFT,
  parameter int unsigned SETS       = 64,
  parameter int unsigned WAYS       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [63:0] lookup_iova,
  output logic        lookup_ready,
  output logic        lookup_done,
  output logic        lookup_hit,
  output logic [63:0] lookup_pa,
  input  logic        upd_valid,
  input  logic [63:0] upd_iova,
  input  logic [63:0] upd_pa,
  output logic        upd_ready,
  output logic        upd_done,
  input  logic        inv_valid,
  input  logic        inv_all,
  input  logic [63:0] inv_iova,
  output logic        inv_ready,
  output logic        inv_done
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = IOVA_W - PAGE_SHIFT - IDX_W;
  localparam int unsigned PPN_W = PA_W - PAGE_SHIFT;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  ioatc_state_e r_state;
  ioatc_state_e w_next_state;

  logic [IOVA_W-1:0] r_iova;
  logic [PPN_W-1:0]  r_fill_ppn;
  logic [WAYS-1:0]   r_valid [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [PPN_W-1:0]  r_ppn   [SETS][WAYS];
  logic [WAY_W-1:0]  r_vptr  [SETS];
  logic [IDX_W-1:0]  r_flush_idx;
  logic              r_lookup_done;
  logic              r_lookup_hit;
  logic [63:0]       r_lookup_pa;
  logic              r_upd_done;
  logic              r_inv_done;

  logic [IDX_W-1:0]            w_idx;
  logic [TAG_W-1:0]            w_tag;
  logic [WAYS-1:0][TAG_W-1:0]  w_set_tags;
  logic [WAYS-1:0]             w_hit_vec;
  logic                        w_hit;
  logic [WAY_W-1:0]            w_hit_way;
  logic                        w_has_inv;
  logic [WAY_W-1:0]            w_inv_way;
  logic [WAY_W-1:0]            w_fill_way;
  logic [WAY_W-1:0]            w_vptr_next;
  logic                        w_idle;
  logic                        w_acc_inv;
  logic                        w_acc_upd;
  logic                        w_acc_lkp;
  logic [IOVA_W-1:0]           w_sel_iova;
  logic                        w_flush_last;
  logic                        w_unused;

  assign w_unused = ^{lookup_iova[63:IOVA_W], upd_iova[63:IOVA_W], inv_iova[63:IOVA_W],
                      upd_pa[63:PA_W], upd_pa[PAGE_SHIFT-1:0]};

  assign w_idx        = r_iova[PAGE_SHIFT +: IDX_W];
  assign w_tag        = r_iova[IOVA_W-1 -: TAG_W];
  assign w_flush_last = (r_flush_idx == IDX_W'(SETS - 1));
  assign w_vptr_next  = (r_vptr[w_idx] == WAY_W'(WAYS - 1)) ? '0 : r_vptr[w_idx] + WAY_W'(1);

  // Fixed-priority acceptance: inv > upd > lookup, only while idle.
  assign w_idle       = (r_state == IDLE) && !rst;
  assign inv_ready    = w_idle;
  assign upd_ready    = w_idle && !inv_valid;
  assign lookup_ready = w_idle && !inv_valid && !upd_valid;
  assign w_acc_inv    = inv_valid && inv_ready;
  assign w_acc_upd    = upd_valid && upd_ready;
  assign w_acc_lkp    = lookup_valid && lookup_ready;

  assign lookup_done = r_lookup_done;
  assign lookup_hit  = r_lookup_hit;
  assign lookup_pa   = r_lookup_pa;
  assign upd_done    = r_upd_done;
  assign inv_done    = r_inv_done;

  // Gather the tags of the addressed set for the way selector.
  always_comb begin
    w_set_tags = '0;
    for (int w = 0; w < WAYS; w++) w_set_tags[w] = r_tag[w_idx][w];
  end

  iommu_ioatc_way_sel #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_way_sel (
    .i_valid    (r_valid[w_idx]),
    .i_tags     (w_set_tags),
    .i_tag      (w_tag),
    .i_vptr     (r_vptr[w_idx]),
    .o_hit_vec  (w_hit_vec),
    .o_hit      (w_hit),
    .o_hit_way  (w_hit_way),
    .o_has_inv  (w_has_inv),
    .o_inv_way  (w_inv_way),
    .o_fill_way (w_fill_way)
  );

  // Next-state and request address selection.
  always_comb begin
    w_next_state = r_state;
    w_sel_iova   = lookup_iova[IOVA_W-1:0];
    case (r_state)
      IDLE: begin
        if (w_acc_inv) begin
          w_next_state = inv_all ? INV_ALL : INV_ONE;
          w_sel_iova   = inv_iova[IOVA_W-1:0];
        end else if (w_acc_upd) begin
          w_next_state = UPDATE;
          w_sel_iova   = upd_iova[IOVA_W-1:0];
        end else if (w_acc_lkp) begin
          w_next_state = LOOKUP;
        end
      end
      INV_ALL: if (w_flush_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Request capture and tag/ppn array writes; these hold no reset state.
  always_ff @(posedge clk) begin
    if (w_acc_inv || w_acc_upd || w_acc_lkp) begin
      r_iova     <= w_sel_iova;
      r_fill_ppn <= upd_pa[PA_W-1:PAGE_SHIFT];
    end
    if (!rst && (r_state == UPDATE)) begin
      r_tag[w_idx][w_fill_way] <= w_tag;
      r_ppn[w_idx][w_fill_way] <= r_fill_ppn;
    end
  end

  // Valid bits, victim pointers, flush walk and result strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_vptr[s]  <= '0;
      end
      r_flush_idx   <= '0;
      r_lookup_done <= 1'b0;
      r_lookup_hit  <= 1'b0;
      r_lookup_pa   <= '0;
      r_upd_done    <= 1'b0;
      r_inv_done    <= 1'b0;
    end else begin
      r_lookup_done <= 1'b0;
      r_lookup_hit  <= 1'b0;
      r_upd_done    <= 1'b0;
      r_inv_done    <= 1'b0;
      case (r_state)
        IDLE: r_flush_idx <= '0;
        LOOKUP: begin
          r_lookup_done <= 1'b1;
          r_lookup_hit  <= w_hit;
          r_lookup_pa   <= w_hit ? 64'({r_ppn[w_idx][w_hit_way], r_iova[PAGE_SHIFT-1:0]}) : '0;
        end
        UPDATE: begin
          r_valid[w_idx][w_fill_way] <= 1'b1;
          if (!w_hit && !w_has_inv) r_vptr[w_idx] <= w_vptr_next;
          r_upd_done <= 1'b1;
        end
        INV_ONE: begin
          r_valid[w_idx] <= r_valid[w_idx] & ~w_hit_vec;
          r_inv_done     <= 1'b1;
        end
        INV_ALL: begin
          r_valid[r_flush_idx] <= '0;
          if (w_flush_last) begin
            for (int s = 0; s < SETS; s++) r_vptr[s] <= '0;
            r_inv_done <= 1'b1;
          end else begin
            r_flush_idx <= r_flush_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
